// File: rtl/sdram_burst_rw_ctrl.sv
// Burst command engine: sequences ACTIVE, WRITE/READ, recovery and PRECHARGE for one
// BURST_LEN burst per request once device init has completed.
module sdram_burst_rw_ctrl #(
   parameter int unsigned RAM_ADDR_W = 24,
   parameter int unsigned DQ_WIDTH   = 16,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned T_RCD      = 2,
   parameter int unsigned T_WR       = 2,
   parameter int unsigned T_RP       = 2,
   parameter int unsigned CAS_LAT    = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_self_refresh_done,
   input  logic                  i_wr_req,
   input  logic                  i_rd_req,
   input  logic [RAM_ADDR_W-1:0] i_burst_addr,
   input  logic [DQ_WIDTH-1:0]   i_wr_data,
   output logic                  o_wr_burst_data_req,
   output logic                  o_wr_burst_finish,
   output logic                  o_wr_done,
   output logic                  o_precharge_done,
   output logic                  o_rd_done,
   output logic [DQ_WIDTH-1:0]   o_rd_data,
   output logic                  o_rd_data_valid,
   output logic                  o_sdram_cs_n,
   output logic                  o_sdram_ras_n,
   output logic                  o_sdram_cas_n,
   output logic                  o_sdram_we_n,
   output logic [1:0]            o_sdram_ba,
   output logic [12:0]           o_sdram_addr,
   output logic [1:0]            o_sdram_dqm,
   output logic [DQ_WIDTH-1:0]   o_sdram_dq_out,
   output logic                  o_sdram_dq_oe,
   input  logic [DQ_WIDTH-1:0]   i_sdram_dq_in
);

   localparam int unsigned Rcd  = (T_RCD == 0) ? 1 : T_RCD;
   localparam int unsigned Twr  = (T_WR == 0) ? 1 : T_WR;
   localparam int unsigned Trp  = (T_RP == 0) ? 1 : T_RP;
   localparam int unsigned Cl   = (CAS_LAT == 0) ? 1 : CAS_LAT;
   localparam int unsigned Bl   = (BURST_LEN == 0) ? 1 : BURST_LEN;
   localparam int unsigned Max1 = (Rcd > Twr) ? Rcd : Twr;
   localparam int unsigned Max2 = (Trp > Cl) ? Trp : Cl;
   localparam int unsigned Max3 = (Max1 > Max2) ? Max1 : Max2;
   localparam int unsigned MaxT = (Max3 > Bl) ? Max3 : Bl;
   localparam int unsigned CntW = $clog2(MaxT + 1);

   localparam logic [CntW-1:0] RcdLast = CntW'(Rcd - 1);
   localparam logic [CntW-1:0] WrLast  = CntW'(Twr - 1);
   localparam logic [CntW-1:0] RpLast  = CntW'(Trp - 1);
   localparam logic [CntW-1:0] BlLast  = CntW'(Bl - 1);
   // READ itself covers one latency cycle, so the wait state only spans the rest
   localparam logic [CntW-1:0] ClLast  = CntW'((Cl > 1) ? Cl - 2 : 0);

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CmdNop   = 4'b0111;
   localparam logic [3:0] CmdAct   = 4'b0011;
   localparam logic [3:0] CmdRead  = 4'b0101;
   localparam logic [3:0] CmdWrite = 4'b0100;
   localparam logic [3:0] CmdPre   = 4'b0010;

   typedef enum logic [3:0] {
      StInitWait, StIdle, StWAct, StRAct, StRcd, StWrBurst, StWrRecov,
      StRdCmd, StClWait, StRdBurst, StPre, StRp
   } state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  is_wr_q, is_wr_d;
   logic                  init_q, init_d;
   logic [RAM_ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]            cmd_q, cmd_d;
   logic [1:0]            ba_q, ba_d;
   logic [12:0]           sd_addr_q, sd_addr_d;
   logic [DQ_WIDTH-1:0]   dq_out_q, dq_out_d, rd_data_q, rd_data_d;
   logic                  dq_oe_q, dq_oe_d, rd_valid_q, rd_valid_d;
   logic                  data_req_q, data_req_d, finish_q, finish_d;
   logic                  wr_done_q, wr_done_d, pre_done_q, pre_done_d, rd_done_q, rd_done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      init_d  = init_q | i_self_refresh_done;
      unique case (state_q)
         StInitWait: begin
            cnt_d = '0;
            if (init_d) state_d = StIdle;
         end
         StIdle: begin
            cnt_d = '0;
            if (i_wr_req) begin
               state_d = StWAct;
               is_wr_d = 1'b1;
               addr_d  = i_burst_addr;
            // the level is still high in the done cycle; upstream drops it one cycle later
            end else if (i_rd_req && !rd_done_q) begin
               state_d = StRAct;
               is_wr_d = 1'b0;
               addr_d  = i_burst_addr;
            end
         end
         StWAct, StRAct: begin
            state_d = StRcd;
            cnt_d   = '0;
         end
         StRcd: if (cnt_q == RcdLast) begin
            state_d = is_wr_q ? StWrBurst : StRdCmd;
            cnt_d   = '0;
         end
         StWrBurst: if (cnt_q == BlLast) begin
            state_d = StWrRecov;
            cnt_d   = '0;
         end
         StWrRecov: if (cnt_q == WrLast) begin
            state_d = StPre;
            cnt_d   = '0;
         end
         StRdCmd: begin
            state_d = (Cl > 1) ? StClWait : StRdBurst;
            cnt_d   = '0;
         end
         StClWait: if (cnt_q == ClLast) begin
            state_d = StRdBurst;
            cnt_d   = '0;
         end
         StRdBurst: if (cnt_q == BlLast) begin
            state_d = StPre;
            cnt_d   = '0;
         end
         StPre: begin
            state_d = StRp;
            cnt_d   = '0;
         end
         StRp: if (cnt_q == RpLast) begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: state_d = StInitWait;
      endcase

      // Commands track the next state so each one is on the pins while its state is current
      cmd_d     = CmdNop;
      ba_d      = ba_q;
      sd_addr_d = sd_addr_q;
      case (state_d)
         StWAct, StRAct: begin
            cmd_d     = CmdAct;
            ba_d      = addr_d[23:22];
            sd_addr_d = addr_d[21:9];
         end
         StRdCmd: begin
            cmd_d     = CmdRead;
            ba_d      = addr_q[23:22];
            sd_addr_d = {4'b0000, addr_q[8:0]};
         end
         StPre: begin
            cmd_d     = CmdPre;
            sd_addr_d = 13'h0400;
         end
         default: ;
      endcase
      // WRITE goes out with the first registered data word
      if (state_q == StWrBurst && cnt_q == '0) begin
         cmd_d     = CmdWrite;
         ba_d      = addr_q[23:22];
         sd_addr_d = {4'b0000, addr_q[8:0]};
      end

      dq_oe_d    = (state_q == StWrBurst);
      dq_out_d   = dq_oe_d ? i_wr_data : dq_out_q;
      rd_valid_d = (state_q == StRdBurst);
      rd_data_d  = rd_valid_d ? i_sdram_dq_in : rd_data_q;
      data_req_d = is_wr_d && state_d == StRcd && cnt_d == RcdLast;
      finish_d   = state_d == StWrBurst && cnt_d == BlLast;
      wr_done_d  = state_d == StPre && is_wr_d;
      pre_done_d = state_q == StRp && cnt_q == RpLast && is_wr_q;
      rd_done_d  = state_q == StRp && cnt_q == RpLast && !is_wr_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StInitWait;
         cnt_q      <= '0;
         is_wr_q    <= 1'b0;
         init_q     <= 1'b0;
         addr_q     <= '0;
         cmd_q      <= CmdNop;
         ba_q       <= '0;
         sd_addr_q  <= '0;
         dq_out_q   <= '0;
         dq_oe_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         data_req_q <= 1'b0;
         finish_q   <= 1'b0;
         wr_done_q  <= 1'b0;
         pre_done_q <= 1'b0;
         rd_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_wr_q    <= is_wr_d;
         init_q     <= init_d;
         addr_q     <= addr_d;
         cmd_q      <= cmd_d;
         ba_q       <= ba_d;
         sd_addr_q  <= sd_addr_d;
         dq_out_q   <= dq_out_d;
         dq_oe_q    <= dq_oe_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         data_req_q <= data_req_d;
         finish_q   <= finish_d;
         wr_done_q  <= wr_done_d;
         pre_done_q <= pre_done_d;
         rd_done_q  <= rd_done_d;
      end
   end

   assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = cmd_q;
   assign o_sdram_ba          = ba_q;
   assign o_sdram_addr        = sd_addr_q;
   assign o_sdram_dqm         = 2'b00;
   assign o_sdram_dq_out      = dq_out_q;
   assign o_sdram_dq_oe       = dq_oe_q;
   assign o_rd_data           = rd_data_q;
   assign o_rd_data_valid     = rd_valid_q;
   assign o_wr_burst_data_req = data_req_q;
   assign o_wr_burst_finish   = finish_q;
   assign o_wr_done           = wr_done_q;
   assign o_precharge_done    = pre_done_q;
   assign o_rd_done           = rd_done_q;

endmodule

// File: tb/tb_sdram_burst_rw_ctrl.sv
// Bench for sdram_burst_rw_ctrl: upstream and SDRAM device models around the DUT, timing rules
// checked on recorded pin events and read data checked against what upstream wrote.
module tb_sdram_burst_rw_ctrl;

   localparam int BL = 8, TRCD = 2, TWR = 2, TRP = 2, CL = 3;
   localparam logic [3:0] CmdNop = 4'b0111, CmdAct = 4'b0011, CmdRead = 4'b0101;
   localparam logic [3:0] CmdWrite = 4'b0100, CmdPre = 4'b0010;

   logic clk = 1'b0;
   logic rst, srd, wr_req, rd_req;
   logic [23:0] burst_addr;
   logic [15:0] wr_data, dq_in, rd_data, dq_out;
   logic data_req, finish, wr_done, pre_done, rd_done, valid;
   logic cs_n, ras_n, cas_n, we_n, dq_oe;
   logic [1:0] ba, dqm;
   logic [12:0] sd_addr;
   logic [3:0] cmd;

   int n_checks = 0, n_pass = 0;
   logic [15:0] words [BL];
   logic [15:0] dev_mem [int];
   logic [15:0] ref_mem [int];

   assign cmd = {cs_n, ras_n, cas_n, we_n};
   always #5 clk = ~clk;

   sdram_burst_rw_ctrl #(
      .RAM_ADDR_W(24), .DQ_WIDTH(16), .BURST_LEN(BL), .T_RCD(TRCD), .T_WR(TWR),
      .T_RP(TRP), .CAS_LAT(CL)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_self_refresh_done(srd), .i_wr_req(wr_req),
      .i_rd_req(rd_req), .i_burst_addr(burst_addr), .i_wr_data(wr_data),
      .o_wr_burst_data_req(data_req), .o_wr_burst_finish(finish), .o_wr_done(wr_done),
      .o_precharge_done(pre_done), .o_rd_done(rd_done), .o_rd_data(rd_data),
      .o_rd_data_valid(valid), .o_sdram_cs_n(cs_n), .o_sdram_ras_n(ras_n),
      .o_sdram_cas_n(cas_n), .o_sdram_we_n(we_n), .o_sdram_ba(ba), .o_sdram_addr(sd_addr),
      .o_sdram_dqm(dqm), .o_sdram_dq_out(dq_out), .o_sdram_dq_oe(dq_oe),
      .i_sdram_dq_in(dq_in)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Watch 8 cycles with an optional wr_req pulse; nothing may happen on the pins
   task automatic idle_watch(input string tag, input bit pulse_wr);
      int busy = 0;
      wr_req = pulse_wr;
      burst_addr = 24'($urandom);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         wr_req = 1'b0;
         if (cmd != CmdNop || dq_oe || data_req || valid || wr_done) busy++;
      end
      chk(tag, busy, 0);
   endtask

   task automatic run(input bit do_wr, input bit do_rd, input bit mid_wr,
                      input logic [23:0] wa, input logic [23:0] ra);
      int cq_cyc[$], oe_cyc[$], vl_cyc[$], req_cyc[$], fin_cyc[$];
      int wd_cyc[$], pd_cyc[$], rd_cyc[$];
      logic [3:0] cq_cmd[$];
      logic [1:0] cq_ba[$];
      logic [12:0] cq_addr[$];
      logic [15:0] oe_dat[$], vl_dat[$];
      logic [1:0] a_ba = '0;
      logic [12:0] a_row = '0;
      int rcmd = -1, rkey = 0, wkey = 0, widx = 0, c = 0, base = 0;
      bit fin = 0;
      if (do_wr) for (int k = 0; k < BL; k++) ref_mem[int'(wa) + k] = words[k];
      wr_req = do_wr;
      rd_req = do_rd;
      burst_addr = do_wr ? wa : ra;
      while (!fin && c < 400) begin
         @(negedge clk);
         c++;
         if (cmd != CmdNop) begin
            cq_cyc.push_back(c); cq_cmd.push_back(cmd);
            cq_ba.push_back(ba); cq_addr.push_back(sd_addr);
            if (cmd == CmdAct) begin a_ba = ba; a_row = sd_addr; end
            if (cmd == CmdRead) begin rcmd = c; rkey = int'({ba, a_row, sd_addr[8:0]}); end
            if (cmd == CmdWrite) begin wkey = int'({ba, a_row, sd_addr[8:0]}); widx = 0; end
         end
         if (dq_oe) begin
            oe_cyc.push_back(c); oe_dat.push_back(dq_out);
            dev_mem[wkey + widx] = dq_out;
            widx++;
         end
         if (valid) begin vl_cyc.push_back(c); vl_dat.push_back(rd_data); end
         if (data_req) req_cyc.push_back(c);
         if (finish) fin_cyc.push_back(c);
         if (wr_done) wd_cyc.push_back(c);
         if (pre_done) pd_cyc.push_back(c);
         if (rd_done) rd_cyc.push_back(c);
         // upstream and device drive for the coming edge
         wr_req = mid_wr && c == 6;
         burst_addr = ra;
         if (req_cyc.size() > 0 && c >= req_cyc[0] + 1 && c <= req_cyc[0] + BL)
            wr_data = words[c - req_cyc[0] - 1];
         else
            wr_data = 16'($urandom);
         if (rcmd >= 0 && c >= rcmd + CL && c < rcmd + CL + BL
             && dev_mem.exists(rkey + c - rcmd - CL))
            dq_in = dev_mem[rkey + c - rcmd - CL];
         else
            dq_in = 16'($urandom);
         if (rd_cyc.size() > 0 && c == rd_cyc[0] + 1) rd_req = 1'b0;
         fin = do_rd ? (rd_cyc.size() > 0 && c >= rd_cyc[0] + 4)
                     : (pd_cyc.size() > 0 && c >= pd_cyc[0] + 2);
      end
      rd_req = 1'b0;
      chk("done_in_budget", fin, 1);
      chk("n_cmds", cq_cmd.size(), (int'(do_wr) + int'(do_rd)) * 3);
      if (cq_cmd.size() != (int'(do_wr) + int'(do_rd)) * 3) return;
      if (do_wr) begin
         chk("w_act", {cq_cmd[0], cq_ba[0], cq_addr[0]}, {CmdAct, wa[23:22], wa[21:9]});
         chk("w_write", {cq_cmd[1], cq_ba[1], cq_addr[1]},
             {CmdWrite, wa[23:22], 4'b0000, wa[8:0]});
         chk("w_trcd", (cq_cyc[1] - cq_cyc[0]) >= TRCD, 1);
         chk("w_req_once", req_cyc.size(), 1);
         chk("w_oe_len", oe_cyc.size(), BL);
         if (req_cyc.size() == 1 && oe_cyc.size() == BL) begin
            chk("w_fin", fin_cyc.size() == 1 ? fin_cyc[0] - req_cyc[0] : -1, BL);
            chk("w_oe_start", oe_cyc[0], cq_cyc[1]);
            chk("w_oe_last", oe_cyc[BL-1] - oe_cyc[0], BL - 1);
            for (int k = 0; k < BL; k++) chk("w_dq", oe_dat[k], words[k]);
            chk("w_twr", (cq_cyc[2] - oe_cyc[BL-1]) >= TWR, 1);
         end
         chk("w_pre", {cq_cmd[2], cq_addr[2][10]}, {CmdPre, 1'b1});
         chk("w_done", wd_cyc.size() == 1 ? wd_cyc[0] - cq_cyc[2] : -1, 0);
         chk("p_done", pd_cyc.size() == 1 ? pd_cyc[0] - cq_cyc[2] : -1, TRP + 1);
         base = 3;
      end else begin
         chk("no_wr_pulses", wd_cyc.size() + pd_cyc.size() + req_cyc.size(), 0);
      end
      if (do_rd) begin
         chk("r_act", {cq_cmd[base], cq_ba[base], cq_addr[base]},
             {CmdAct, ra[23:22], ra[21:9]});
         chk("r_read", {cq_cmd[base+1], cq_ba[base+1], cq_addr[base+1]},
             {CmdRead, ra[23:22], 4'b0000, ra[8:0]});
         chk("r_trcd", (cq_cyc[base+1] - cq_cyc[base]) >= TRCD, 1);
         chk("r_vlen", vl_cyc.size(), BL);
         if (vl_cyc.size() == BL) begin
            chk("r_vstart", vl_cyc[0] - cq_cyc[base+1], CL + 1);
            chk("r_vlast", vl_cyc[BL-1] - vl_cyc[0], BL - 1);
            for (int k = 0; k < BL; k++) chk("r_data", vl_dat[k], ref_mem[int'(ra) + k]);
            chk("r_pre_after", cq_cyc[base+2] >= vl_cyc[BL-1], 1);
         end
         chk("r_pre", {cq_cmd[base+2], cq_addr[base+2][10]}, {CmdPre, 1'b1});
         chk("r_done", rd_cyc.size() == 1 ? rd_cyc[0] - cq_cyc[base+2] : -1, TRP + 1);
         if (do_wr) chk("no_overlap", pd_cyc.size() == 1 && cq_cyc[base] > pd_cyc[0], 1);
      end
   endtask

   task automatic reset_outputs(input string tag);
      chk({tag, "_cmd"}, cmd, CmdNop);
      chk({tag, "_oe"}, dq_oe, 0);
      chk({tag, "_pulses"}, {data_req, finish, wr_done, pre_done, rd_done, valid}, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
   endtask

   initial begin
      logic [23:0] a;
      bit seen;
      rst = 1'b1; srd = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      burst_addr = '0; wr_data = '0; dq_in = '0;
      repeat (3) @(negedge clk);
      reset_outputs("rst");
      chk("rst_ba_addr", {ba, sd_addr, dq_out}, 0);
      chk("rst_dqm", dqm, 0);
      rst = 1'b0;

      idle_watch("wr_before_init", 1'b1);
      srd = 1'b1;
      @(negedge clk);
      srd = 1'b0;
      @(negedge clk);

      // directed write 2..16 at 0x000010, then read it back with a stray wr_req mid-read
      for (int k = 0; k < BL; k++) words[k] = 16'(2 * (k + 1));
      run(1'b1, 1'b0, 1'b0, 24'h000010, 24'h000010);
      run(1'b0, 1'b1, 1'b1, 24'h000010, 24'h000010);

      for (int i = 0; i < 4; i++) begin
         a = 24'($urandom);
         for (int k = 0; k < BL; k++) words[k] = 16'($urandom);
         if (i % 2 == 1) begin
            run(1'b1, 1'b1, 1'b0, a, a);
         end else begin
            run(1'b1, 1'b0, 1'b0, a, a);
            run(1'b0, 1'b1, 1'b0, a, a);
         end
      end

      // reset in the middle of a write burst
      wr_req = 1'b1;
      burst_addr = 24'($urandom);
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         wr_req = 1'b0;
         wr_data = 16'($urandom);
         if (dq_oe) seen = 1;
      end
      chk("rst_reach_burst", seen, 1);
      rst = 1'b1;
      @(negedge clk);
      reset_outputs("midrst");
      rst = 1'b0;
      idle_watch("wr_after_midrst", 1'b1);

      srd = 1'b1;
      @(negedge clk);
      srd = 1'b0;
      @(negedge clk);
      a = 24'($urandom);
      for (int k = 0; k < BL; k++) words[k] = 16'($urandom);
      run(1'b1, 1'b1, 1'b0, a, a);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
